// File: rtl/median3x3_core.sv
// 3x3 median filter core: three-stage sorting-network pipeline with border
// pass-through and adaptive salt-and-pepper replacement of the centre pixel.
module median3x3_core #(
    parameter int WIDTH       = 512,
    parameter int HEIGHT      = 512,
    parameter int BORDER_PASS = 1,
    parameter int ADAPTIVE    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       win_valid,
    output logic       win_ready,
    input  logic       win_last,
    input  logic [9:0] Row_i,
    input  logic [9:0] Col_i,
    input  logic [7:0] D0,
    input  logic [7:0] D1,
    input  logic [7:0] D2,
    input  logic [7:0] D3,
    input  logic [7:0] D4,
    input  logic [7:0] D5,
    input  logic [7:0] D6,
    input  logic [7:0] D7,
    input  logic [7:0] D8,
    output logic       pix_valid,
    input  logic       out_ready,
    output logic [7:0] pix_out,
    output logic [9:0] Row_o,
    output logic [9:0] Col_o,
    output logic       pix_last,
    output logic       done
);

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Three compare-exchanges; result packed as {max, mid, min}.
    function automatic logic [23:0] sort3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [7:0] x, y, z, t;
        x = a;
        y = b;
        z = c;
        if (x < y) begin t = x; x = y; y = t; end
        if (y < z) begin t = y; y = z; z = t; end
        if (x < y) begin t = x; x = y; y = t; end
        return {x, y, z};
    endfunction

    // Valid/ready: a beat transfers on win_valid && win_ready, an output pixel on
    // pix_valid && out_ready. The whole pipeline advances only while out_ready is
    // high, so win_ready mirrors out_ready and a stalled pix_valid holds its data.
    logic en;
    logic accept;
    logic done_set;
    logic done_r;

    assign en        = out_ready;
    assign win_ready = out_ready;
    assign accept    = win_valid && win_ready;
    assign done_set  = pix_valid && pix_last && out_ready;
    assign done      = done_r || done_set;

    logic [23:0] r0_c, r1_c, r2_c;
    logic        border_c;

    assign r0_c     = sort3(D0, D1, D2);
    assign r1_c     = sort3(D3, D4, D5);
    assign r2_c     = sort3(D6, D7, D8);
    assign border_c = (Row_i == 10'd0) || (Row_i == 10'(HEIGHT - 1)) ||
                      (Col_i == 10'd0) || (Col_i == 10'(WIDTH - 1));

    logic        s1_valid, s1_last, s1_border;
    logic [23:0] s1_r0, s1_r1, s1_r2;
    logic [7:0]  s1_d4;
    logic [9:0]  s1_row, s1_col;

    logic [7:0] lo_c, mi_c, hi_c;

    assign lo_c = max2(max2(s1_r0[7:0], s1_r1[7:0]), s1_r2[7:0]);
    assign mi_c = med3(s1_r0[15:8], s1_r1[15:8], s1_r2[15:8]);
    assign hi_c = min2(min2(s1_r0[23:16], s1_r1[23:16]), s1_r2[23:16]);

    logic       s2_valid, s2_last, s2_border;
    logic [7:0] s2_lo, s2_mi, s2_hi, s2_d4;
    logic [9:0] s2_row, s2_col;

    logic [7:0] med_c;
    logic [7:0] sel_c;

    assign med_c = med3(s2_lo, s2_mi, s2_hi);

    always_comb begin
        sel_c = med_c;
        if ((BORDER_PASS != 0) && s2_border) begin
            sel_c = s2_d4;
        end else if ((ADAPTIVE != 0) && (s2_d4 != 8'd0) && (s2_d4 != 8'd255)) begin
            sel_c = s2_d4;
        end
    end

    // Data registers load only with a valid beat so bubbles leave tags untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_border <= 1'b0;
            s1_r0     <= '0;
            s1_r1     <= '0;
            s1_r2     <= '0;
            s1_d4     <= '0;
            s1_row    <= '0;
            s1_col    <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_border <= 1'b0;
            s2_lo     <= '0;
            s2_mi     <= '0;
            s2_hi     <= '0;
            s2_d4     <= '0;
            s2_row    <= '0;
            s2_col    <= '0;
            pix_valid <= 1'b0;
            pix_out   <= '0;
            Row_o     <= '0;
            Col_o     <= '0;
            pix_last  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= done_set || (done_r && !accept);
            if (en) begin
                s1_valid <= win_valid;
                if (win_valid) begin
                    s1_r0     <= r0_c;
                    s1_r1     <= r1_c;
                    s1_r2     <= r2_c;
                    s1_d4     <= D4;
                    s1_row    <= Row_i;
                    s1_col    <= Col_i;
                    s1_last   <= win_last;
                    s1_border <= border_c;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_lo     <= lo_c;
                    s2_mi     <= mi_c;
                    s2_hi     <= hi_c;
                    s2_d4     <= s1_d4;
                    s2_row    <= s1_row;
                    s2_col    <= s1_col;
                    s2_last   <= s1_last;
                    s2_border <= s1_border;
                end
                pix_valid <= s2_valid;
                if (s2_valid) begin
                    pix_out  <= sel_c;
                    Row_o    <= s2_row;
                    Col_o    <= s2_col;
                    pix_last <= s2_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_median3x3_core.sv
// Directed testbench for median3x3_core: three parameter variants share one
// input stimulus; each scenario task checks its own expected values.
module tb_median3x3_core;

    logic       clk;
    logic       rst;
    logic       win_valid;
    logic       win_last;
    logic       out_ready;
    logic [9:0] Row_i, Col_i;
    logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7, D8;

    logic       win_ready, pix_valid, pix_last, done;
    logic [7:0] pix_out;
    logic [9:0] Row_o, Col_o;

    logic       na_win_ready, na_pix_valid, na_pix_last, na_done;
    logic [7:0] na_pix_out;
    logic [9:0] na_Row_o, na_Col_o;

    logic       nb_win_ready, nb_pix_valid, nb_pix_last, nb_done;
    logic [7:0] nb_pix_out;
    logic [9:0] nb_Row_o, nb_Col_o;

    int tests_run    = 0;
    int tests_failed = 0;

    median3x3_core u_dut (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready),
        .win_last(win_last), .Row_i(Row_i), .Col_i(Col_i),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7), .D8(D8),
        .pix_valid(pix_valid), .out_ready(out_ready), .pix_out(pix_out),
        .Row_o(Row_o), .Col_o(Col_o), .pix_last(pix_last), .done(done)
    );

    median3x3_core #(.ADAPTIVE(0)) u_na (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(na_win_ready),
        .win_last(win_last), .Row_i(Row_i), .Col_i(Col_i),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7), .D8(D8),
        .pix_valid(na_pix_valid), .out_ready(out_ready), .pix_out(na_pix_out),
        .Row_o(na_Row_o), .Col_o(na_Col_o), .pix_last(na_pix_last), .done(na_done)
    );

    median3x3_core #(.BORDER_PASS(0)) u_nb (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(nb_win_ready),
        .win_last(win_last), .Row_i(Row_i), .Col_i(Col_i),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7), .D8(D8),
        .pix_valid(nb_pix_valid), .out_ready(out_ready), .pix_out(nb_pix_out),
        .Row_o(nb_Row_o), .Col_o(nb_Col_o), .pix_last(nb_pix_last), .done(nb_done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic v, input logic [71:0] w, input logic [9:0] r,
                           input logic [9:0] c, input logic l);
        win_valid = v;
        win_last  = l;
        Row_i     = r;
        Col_i     = c;
        D0 = w[71:64]; D1 = w[63:56]; D2 = w[55:48];
        D3 = w[47:40]; D4 = w[39:32]; D5 = w[31:24];
        D6 = w[23:16]; D7 = w[15:8];  D8 = w[7:0];
    endtask

    // Reference model: full sort of nine values, then centre-pixel selection
    function automatic logic [7:0] ref_median(input logic [71:0] w);
        logic [7:0] a[9];
        logic [7:0] t;
        for (int k = 0; k < 9; k++) a[k] = w[71 - 8*k -: 8];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    function automatic logic [7:0] ref_interior(input logic [71:0] w);
        logic [7:0] c;
        c = w[39:32];
        return (c == 8'd0 || c == 8'd255) ? ref_median(w) : c;
    endfunction

    function automatic logic [71:0] gen_win(input int i);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[71 - 8*k -: 8] = 8'((i*37 + k*53 + 11) & 255);
        case (i % 3)
            0:       w[39:32] = 8'd0;
            1:       w[39:32] = 8'd255;
            default: w[39:32] = 8'(100 + i);
        endcase
        return w;
    endfunction

    localparam logic [71:0] WIN_A = {8'd10, 8'd200, 8'd30, 8'd40, 8'd0, 8'd60, 8'd70, 8'd80, 8'd90};
    localparam logic [71:0] WIN_B = {8'd10, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    localparam logic [71:0] WIN_C = {8'd12, 8'd12, 8'd12, 8'd12, 8'd255, 8'd12, 8'd12, 8'd12, 8'd12};

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        set_win(1'b0, '0, '0, '0, 1'b0);
        tick(); tick();
        tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
        tests_run++; if (pix_out !== 8'd0) begin tests_failed++; $display("FAIL reset_pix_out got %0d want 0", pix_out); end
        tests_run++; if (Row_o !== 10'd0 || Col_o !== 10'd0) begin tests_failed++; $display("FAIL reset_tags got %0d/%0d want 0/0", Row_o, Col_o); end
        tests_run++; if (pix_last !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_last_done got %b/%b want 0/0", pix_last, done); end
        tests_run++; if (win_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_win_ready_hi got %b want 1", win_ready); end
        out_ready = 1'b0;
        #1;
        tests_run++; if (win_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_win_ready_lo got %b want 0", win_ready); end
        out_ready = 1'b1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_median();
        set_win(1'b1, WIN_A, 10'd5, 10'd7, 1'b0);
        tick();
        set_win(1'b0, WIN_A, 10'd5, 10'd7, 1'b0);
        tick();
        tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL median_early got pix_valid %b want 0", pix_valid); end
        tick();
        tests_run++; if (pix_valid !== 1'b1) begin tests_failed++; $display("FAIL median_valid got %b want 1", pix_valid); end
        tests_run++; if (pix_out !== 8'd60) begin tests_failed++; $display("FAIL median_pix got %0d want 60", pix_out); end
        tests_run++; if (na_pix_out !== 8'd60) begin tests_failed++; $display("FAIL median_pix_noadapt got %0d want 60", na_pix_out); end
        tests_run++; if (nb_pix_out !== 8'd60) begin tests_failed++; $display("FAIL median_pix_noborder got %0d want 60", nb_pix_out); end
        tests_run++; if (Row_o !== 10'd5 || Col_o !== 10'd7) begin tests_failed++; $display("FAIL median_tags got %0d/%0d want 5/7", Row_o, Col_o); end
        tick();
        tests_run++; if (pix_valid !== 1'b0 || pix_out !== 8'd60) begin tests_failed++; $display("FAIL median_bubble got valid %b pix %0d want 0 60", pix_valid, pix_out); end
    endtask

    task automatic test_adaptive();
        set_win(1'b1, WIN_B, 10'd5, 10'd7, 1'b0);
        tick();
        set_win(1'b0, WIN_B, 10'd5, 10'd7, 1'b0);
        tick(); tick();
        tests_run++; if (pix_valid !== 1'b1 || pix_out !== 8'd50) begin tests_failed++; $display("FAIL adaptive_keep got valid %b pix %0d want 1 50", pix_valid, pix_out); end
        tests_run++; if (na_pix_out !== 8'd60) begin tests_failed++; $display("FAIL adaptive_off got %0d want 60", na_pix_out); end
        tick();
    endtask

    task automatic test_border();
        set_win(1'b1, WIN_C, 10'd0, 10'd3, 1'b0);
        tick();
        set_win(1'b0, WIN_C, 10'd0, 10'd3, 1'b0);
        tick(); tick();
        tests_run++; if (pix_valid !== 1'b1 || pix_out !== 8'd255) begin tests_failed++; $display("FAIL border_pass got valid %b pix %0d want 1 255", pix_valid, pix_out); end
        tests_run++; if (nb_pix_out !== 8'd12) begin tests_failed++; $display("FAIL border_filter got %0d want 12", nb_pix_out); end
        tick();
        // Last column of the frame is also a border position
        set_win(1'b1, WIN_C, 10'd9, 10'd511, 1'b0);
        tick();
        set_win(1'b0, WIN_C, 10'd9, 10'd511, 1'b0);
        tick(); tick();
        tests_run++; if (pix_out !== 8'd255 || nb_pix_out !== 8'd12) begin tests_failed++; $display("FAIL border_lastcol got %0d/%0d want 255/12", pix_out, nb_pix_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [9:0] col_q[$];
        logic [7:0] e;
        logic [9:0] ec;
        int n = 0;
        int first_c = -1;
        int last_c = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(ref_interior(gen_win(i)));
            col_q.push_back(10'(i + 1));
        end
        for (int c = 0; c < 40; c++) begin
            if (c < 20) set_win(1'b1, gen_win(c), 10'd10, 10'(c + 1), 1'b0);
            else        set_win(1'b0, '0, 10'd10, 10'd0, 1'b0);
            #1;
            if (pix_valid === 1'b1) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                e  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                ec = (col_q.size() > 0) ? col_q.pop_front() : 10'h3ff;
                tests_run++; if (pix_out !== e) begin tests_failed++; $display("FAIL b2b_pix[%0d] got %0d want %0d", n, pix_out, e); end
                tests_run++; if (Row_o !== 10'd10 || Col_o !== ec) begin tests_failed++; $display("FAIL b2b_tag[%0d] got %0d/%0d want 10/%0d", n, Row_o, Col_o, ec); end
                n++;
            end
            tick();
        end
        tests_run++; if (n !== 20) begin tests_failed++; $display("FAIL b2b_count got %0d want 20", n); end
        tests_run++; if (first_c !== 3) begin tests_failed++; $display("FAIL b2b_latency got %0d want 3", first_c); end
        tests_run++; if (last_c !== 22) begin tests_failed++; $display("FAIL b2b_contiguous got last %0d want 22", last_c); end
    endtask

    task automatic test_stall();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic       f_valid;
        logic [7:0] f_pix;
        logic [9:0] f_row;
        int idx = 0;
        int n = 0;
        int c = 0;
        for (int i = 0; i < 10; i++) exp_q.push_back(ref_interior(gen_win(i + 50)));
        while (n < 10 && c < 80) begin
            out_ready = !(c >= 5 && c < 9);
            if (idx < 10) set_win(1'b1, gen_win(idx + 50), 10'(idx + 100), 10'd20, 1'b0);
            else          set_win(1'b0, '0, 10'd0, 10'd0, 1'b0);
            #1;
            tests_run++; if (win_ready !== out_ready) begin tests_failed++; $display("FAIL stall_win_ready c=%0d got %b want %b", c, win_ready, out_ready); end
            if (c == 5) begin
                f_valid = pix_valid; f_pix = pix_out; f_row = Row_o;
            end else if (c > 5 && c < 9) begin
                tests_run++; if (pix_valid !== f_valid || pix_out !== f_pix || Row_o !== f_row) begin
                    tests_failed++; $display("FAIL stall_frozen c=%0d got %b/%0d/%0d want %b/%0d/%0d", c, pix_valid, pix_out, Row_o, f_valid, f_pix, f_row); end
            end
            if (pix_valid === 1'b1 && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                tests_run++; if (pix_out !== e || Row_o !== 10'(n + 100)) begin
                    tests_failed++; $display("FAIL stall_out[%0d] got %0d row %0d want %0d row %0d", n, pix_out, Row_o, e, n + 100); end
                n++;
            end
            if (win_valid && out_ready) idx++;
            tick();
            c++;
        end
        out_ready = 1'b1;
        set_win(1'b0, '0, 10'd0, 10'd0, 1'b0);
        tests_run++; if (n !== 10 || f_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_count got %0d stalled_valid %b want 10 1", n, f_valid); end
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_dup k=%0d got pix_valid %b want 0", k, pix_valid); end
            tick();
        end
    endtask

    task automatic test_last_done();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL done_idle got %b want 0", done); end
        set_win(1'b1, WIN_A, 10'd30, 10'd40, 1'b1);
        tick();
        set_win(1'b0, WIN_A, 10'd30, 10'd40, 1'b0);
        tick(); tick();
        tests_run++; if (pix_valid !== 1'b1 || pix_last !== 1'b1) begin tests_failed++; $display("FAIL last_fwd got valid %b last %b want 1 1", pix_valid, pix_last); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_rise got %b want 1", done); end
        tick();
        tests_run++; if (pix_valid !== 1'b0 || done !== 1'b1) begin tests_failed++; $display("FAIL done_sticky got valid %b done %b want 0 1", pix_valid, done); end
        tick(); tick();
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_hold got %b want 1", done); end
        set_win(1'b1, WIN_A, 10'd31, 10'd40, 1'b0);
        tick();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL done_clear got %b want 0", done); end
        set_win(1'b1, WIN_A, 10'd32, 10'd40, 1'b0);
        tick();
        set_win(1'b0, '0, 10'd0, 10'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (pix_valid !== 1'b0 || done !== 1'b0 || pix_out !== 8'd0) begin
            tests_failed++; $display("FAIL rst_flight got valid %b done %b pix %0d want 0 0 0", pix_valid, done, pix_out); end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_dropped k=%0d got pix_valid %b want 0", k, pix_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_median();
        test_adaptive();
        test_border();
        test_back_to_back();
        test_stall();
        test_last_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/median3x3_core.md
Name: median3x3_core

Overview:
- Consumer end of the 3x3 window interface produced by the image window generator: accepts one raster-ordered 3x3 window per beat (D0..D8 plus row/column tag).
- Computes the median through a 3-stage pipeline and emits one filtered pixel per window with the tag forwarded, for the output image writer.
- Supports adaptive salt-and-pepper mode: only pixels whose centre is 0 or 255 are replaced.

Parameters:
- WIDTH, 512, image width in pixels; defines the last column (WIDTH-1).
- HEIGHT, 512, image height in pixels; defines the last row (HEIGHT-1).
- BORDER_PASS, 1, 1 = border pixels output the centre D4 unfiltered; 0 = border pixels are filtered like interior pixels.
- ADAPTIVE, 1, 1 = replace only when D4 is 8'd0 or 8'd255; 0 = always output the median.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- win_valid  in  1  window beat valid.
- win_ready  out  1  core can accept a beat; equals out_ready.
- win_last  in  1  beat carries the final window of the frame.
- Row_i  in  10  row of the window centre.
- Col_i  in  10  column of the window centre.
- D0..D8  in  8 each  window pixels in raster order; D4 is the centre.
- pix_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- pix_out  out  8  filtered pixel.
- Row_o  out  10  forwarded row.
- Col_o  out  10  forwarded column.
- pix_last  out  1  forwarded win_last.
- done  out  1  frame complete, sticky.

Behaviour:
- Reset values: all outputs 0 except win_ready, which follows out_ready combinationally. All stage valid bits cleared, so in-flight data is dropped on reset mid-frame.
- Pipeline enable en = out_ready.
  - en=0 freezes every stage register, including pix_valid and pix_out; pix_valid therefore holds until accepted.
  - A beat is accepted when win_valid && win_ready.
- Stage 1, registered: sort each row {D0,D1,D2}, {D3,D4,D5}, {D6,D7,D8} into max/mid/min using 3 compare-exchanges per row.
  - Also register D4, the tag, the last flag, and border = (Row_i==0 || Row_i==HEIGHT-1 || Col_i==0 || Col_i==WIDTH-1).
- Stage 2, registered: three values.
  - lo = max of the three row maxima' minima... precisely lo = max(min0,min1,min2).
  - mi = median(mid0,mid1,mid2).
  - hi = min(max0,max1,max2).
- Stage 3, registered output: med = median(lo,mi,hi).
  - Selection: if (BORDER_PASS && border) pix_out = D4; else if (ADAPTIVE && D4!=0 && D4!=255) pix_out = D4; else pix_out = med.
- Latency: an accepted beat appears on pix_valid exactly 3 enabled cycles later. Throughput is 1 pixel per cycle while out_ready=1.
- Arithmetic: unsigned 8-bit comparisons only; ties keep either operand, since the result value is identical. No widening.
- Ordering: outputs are strictly in input order. Tags, pix_last and D4 travel in lockstep with their data.
- done:
  - Set on the cycle pix_valid && pix_last && out_ready.
  - Cleared when the next beat is accepted, or by rst.
  - If both happen in the same cycle, set wins.
- Bubbles (win_valid=0 with en=1) propagate as pix_valid=0; pix_out and tags hold their last value.
- Window construction, padding and file I/O are not part of this block.

Test Plan:
- Interior window D0..D8 = 10,200,30,40,0,60,70,80,90, Row_i=5, Col_i=7, ADAPTIVE=1 -> 3 cycles later pix_valid=1, pix_out=60, Row_o=5, Col_o=7.
- Same window with D4 = 50, ADAPTIVE=1 -> pix_out=50, since the centre is not noisy; with ADAPTIVE=0 -> pix_out=60.
- Border window Row_i=0, Col_i=3, D4=255, others 12, BORDER_PASS=1 -> pix_out=255; with BORDER_PASS=0 -> pix_out=12.
- 20 back-to-back windows with out_ready held at 1 -> 20 consecutive pix_valid cycles in input order, first output 3 cycles after the first beat.
- out_ready deasserted for 4 cycles mid-stream -> win_ready=0, pix_valid/pix_out/Row_o frozen; no pixel lost or duplicated after resume.
- Final beat with win_last=1 -> pix_last=1 and done rises the same cycle and stays high. rst asserted with 2 beats in flight -> next cycle pix_valid=0, done=0, and those beats never appear.
